// File: rtl/beta_data_mem_responder.sv
`default_nettype none
// ============================================================================
// beta_data_mem_responder: data-memory responder for the Beta core with a
// programmable response latency, word RAM and alignment/range fault reporting.
// Revision: 1.0
// ============================================================================
module beta_data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataAddress,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [31:0] DataWrite,
  output logic [31:0] DataRead,
  output logic        dataReady,
  output logic        dMemfault,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       data_read_q, data_read_d;

  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              in_fault;
  logic              enter_resp;
  logic [ADDR_W-1:0] resp_idx;
  logic              resp_we;
  logic              resp_fault;
  logic [31:0]       resp_wdata;
  logic              mem_we;

  assign req      = ReadEnable | WriteEnable;
  assign in_fault = (DataAddress[1:0] != 2'b00)
                  | ({1'b0, DataAddress} >= ADDR_LIMIT)
                  | (ReadEnable & WriteEnable);

  // With LATENCY==1 the RESP-entry edge is the capture edge, so the request
  // is taken straight from the inputs instead of the capture registers.
  always_comb begin
    if (state_q == IDLE) begin
      resp_idx   = DataAddress[ADDR_W+1:2];
      resp_we    = WriteEnable;
      resp_fault = in_fault;
      resp_wdata = DataWrite;
    end else begin
      resp_idx   = idx_q;
      resp_we    = we_q;
      resp_fault = fault_q;
      resp_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    data_read_d = data_read_q;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;
    dataReady   = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        dataReady = ~req;
        if (req) begin
          idx_d   = DataAddress[ADDR_W+1:2];
          we_d    = WriteEnable;
          wdata_d = DataWrite;
          fault_d = in_fault;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        busy      = 1'b1;
        dataReady = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_resp) begin
      if (resp_fault) begin
        data_read_d = 32'd0;
      end else if (resp_we) begin
        mem_we = 1'b1;
      end else begin
        data_read_d = mem[resp_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      fault_q     <= 1'b0;
      data_read_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      data_read_q <= data_read_d;
    end
  end

  // RAM survives reset, but a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[resp_idx] <= resp_wdata;
    end
  end

  assign DataRead  = data_read_q;
  assign dMemfault = (state_q == RESP) & fault_q;

endmodule
`default_nettype wire

// File: tb/tb_beta_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_beta_data_mem_responder: directed checks of three responder instances
// (LATENCY 2, 1 and 5) sharing clock and reset.
// Revision: 1.0
// ============================================================================
module tb_beta_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr_s [3];
  logic [31:0] wd_s   [3];
  logic        re_s   [3];
  logic        we_s   [3];
  logic [31:0] rd_s   [3];
  logic        rdy_s  [3];
  logic        flt_s  [3];
  logic        busy_s [3];

  int n_pass  = 0;
  int n_total = 0;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      beta_data_mem_responder #(
        .DEPTH  (1024),
        .LATENCY((k == 0) ? 2 : ((k == 1) ? 1 : 5)),
        .ADDR_W (10)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .DataAddress(addr_s[k]),
        .ReadEnable (re_s[k]),
        .WriteEnable(we_s[k]),
        .DataWrite  (wd_s[k]),
        .DataRead   (rd_s[k]),
        .dataReady  (rdy_s[k]),
        .dMemfault  (flt_s[k]),
        .busy       (busy_s[k])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request on instance k, hold it until dataReady, report the
  // number of stalled cycles and the RESP-cycle outputs.
  task automatic txn(input int k, input logic re, input logic we,
                     input logic [31:0] a, input logic [31:0] d, input bit hold,
                     output logic [31:0] rd, output logic flt, output logic bsy,
                     output int low);
    bit done;
    @(negedge clk);
    re_s[k] = re; we_s[k] = we; addr_s[k] = a; wd_s[k] = d;
    low = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (rdy_s[k]) done = 1;
      else begin
        low++;
        @(negedge clk);
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    rd = rd_s[k]; flt = flt_s[k]; bsy = busy_s[k];
    @(posedge clk); #1;
    if (!hold) begin
      re_s[k] = 1'b0; we_s[k] = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic        flt, bsy;
  int          low;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_s[k] = 32'd0; wd_s[k] = 32'd0; re_s[k] = 1'b0; we_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle state
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("idle_ready", rdy_s[k], 1);
        check("idle_busy",  busy_s[k], 0);
        check("idle_rd",    rd_s[k], 0);
        check("idle_fault", flt_s[k], 0);
      end
    end

    // LATENCY=2 write then read
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, rd, flt, bsy, low);
    check("wr_low", low, 2); check("wr_fault", flt, 0);
    check("wr_rd_unchanged", rd, 32'd0); check("wr_busy", bsy, 1);
    check("after_resp_busy", busy_s[0], 0);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rd, flt, bsy, low);
    check("rd_low", low, 2); check("rd_data", rd, 32'hDEADBEEF); check("rd_fault", flt, 0);

    // LATENCY=1 and 5
    txn(1, 1, 0, 32'h0, 32'h0, 0, rd, flt, bsy, low);
    check("lat1_low", low, 1); check("lat1_fault", flt, 0);
    check("lat1_single_high", busy_s[1], 0);
    txn(2, 1, 0, 32'h0, 32'h0, 0, rd, flt, bsy, low);
    check("lat5_low", low, 5); check("lat5_fault", flt, 0);
    check("lat5_single_high", busy_s[2], 0);

    // Preload known words, then faults must not touch them
    txn(0, 0, 1, 32'h0, 32'h11112222, 0, rd, flt, bsy, low);
    txn(0, 0, 1, 32'h4, 32'h33334444, 0, rd, flt, bsy, low);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rd, flt, bsy, low);
    check("pre_rd", rd, 32'hDEADBEEF);
    txn(0, 1, 0, 32'h2, 32'h0, 0, rd, flt, bsy, low);
    check("misal_fault", flt, 1); check("misal_rd", rd, 0); check("misal_low", low, 2);
    check("fault_cleared_idle", flt_s[0], 0);
    txn(0, 0, 1, 32'h1000, 32'h55555555, 0, rd, flt, bsy, low);
    check("oor_fault", flt, 1); check("oor_rd", rd, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rd, flt, bsy, low);
    txn(0, 1, 1, 32'h4, 32'h66666666, 0, rd, flt, bsy, low);
    check("both_fault", flt, 1); check("both_rd", rd, 0);
    txn(0, 1, 0, 32'h0, 32'h0, 0, rd, flt, bsy, low);
    check("ram0_kept", rd, 32'h11112222); check("ram0_fault", flt, 0);
    txn(0, 1, 0, 32'h4, 32'h0, 0, rd, flt, bsy, low);
    check("ram4_kept", rd, 32'h33334444);

    // Back-to-back reads with enables held
    txn(0, 0, 1, 32'h8, 32'hCCCC0008, 0, rd, flt, bsy, low);
    txn(0, 0, 1, 32'hC, 32'hDDDD000C, 0, rd, flt, bsy, low);
    txn(0, 1, 0, 32'h8, 32'h0, 1, rd, flt, bsy, low);
    check("b2b_first", rd, 32'hCCCC0008);
    txn(0, 1, 0, 32'hC, 32'h0, 0, rd, flt, bsy, low);
    check("b2b_second", rd, 32'hDDDD000C); check("b2b_gap", low, 2);

    // Reset during WAIT discards a pending write
    txn(0, 0, 1, 32'h20, 32'hAAAA5555, 0, rd, flt, bsy, low);
    @(negedge clk);
    we_s[0] = 1'b1; addr_s[0] = 32'h20; wd_s[0] = 32'h12345678;
    @(posedge clk); #1;
    check("wait_busy", busy_s[0], 1); check("wait_ready", rdy_s[0], 0);
    @(negedge clk);
    rst = 1'b1; we_s[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", rdy_s[0], 1); check("rst_busy", busy_s[0], 0);
    check("rst_rd", rd_s[0], 0);
    txn(0, 1, 0, 32'h20, 32'h0, 0, rd, flt, bsy, low);
    check("rst_write_dropped", rd, 32'hAAAA5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
